ram_access_ctrl: RTL and testbench

Initiator-side controller for the team's single-port synchronous RAM (one-cycle read latency, read-first on simultaneous read/write of the same address). It accepts valid/ready read and write requests from a client and drives the RAM's `we`/`addr`/`din` pins. It captures `dout` into a held response with valid/ready backpressure, and can fill the whole array with a constant after reset or on command.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_access_ctrl.sv | 125 ++++++++++++
 tb/tb_ram_access_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM access controller.
// Holds the FSM state encoding and the default data/address widths.
package ram_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2,
    ST_INIT    = 2'd3
  } ctrl_state_t;

endpackage : ram_pkg

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for a single-port synchronous RAM (1-cycle read
// latency). Accepts valid/ready read/write requests, returns read data as a
// held valid/ready response, and can fill the array with INIT_VALUE.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                 client request channel
//   rsp_valid/rsp_ready/rsp_rdata      client read response channel
//   init_start, init_busy              fill request / fill pending-or-running
//   ram_we/ram_addr/ram_din, ram_dout  RAM pins
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned             ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE    = '0,
  parameter bit                      INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  ctrl_state_t           state_q, state_d;
  logic                  init_req_q, init_req_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      init_req_q <= 1'(INIT_ON_RESET);
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      init_req_q <= init_req_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

  // Next-state, register updates and RAM/handshake outputs
  always_comb begin
    state_d     = state_q;
    init_req_d  = init_req_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    req_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = rd_addr_q;
    ram_din     = req_wdata;

    unique case (state_q)
      ST_IDLE: begin
        ram_addr = req_addr;
        // A pending or new fill wins over any client request this cycle
        if (init_req_q || init_start) begin
          state_d    = ST_INIT;
          init_req_d = 1'b0;
          cnt_d      = '0;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (req_we) begin
              ram_we = 1'b1;
            end else begin
              rd_addr_d = req_addr;
              state_d   = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        // RAM output is valid one edge after the address was sampled
        rsp_rdata_d = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_INIT: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = INIT_VALUE;
        cnt_d    = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign init_busy = init_req_q || (state_q == ST_INIT);

endmodule : ram_access_ctrl

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural read-first RAM.
// Inputs are driven on the falling edge and outputs compared 1 ns later.
module tb_ram_access_ctrl;
  import ram_pkg::*;

  localparam int unsigned DW = DEF_DATA_WIDTH;
  localparam int unsigned AW = DEF_ADDR_WIDTH;
  localparam logic [DW-1:0] IV = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_start, init_busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] mem [2**AW];

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] last_rd;

  typedef struct {
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          rr;
    logic          is;
    logic          e_rq;
    logic          e_we;
    logic [AW-1:0] e_ra;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_busy;
  } vec_t;

  vec_t tbl [18];

  ram_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(IV), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_busy(init_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port synchronous RAM, read-first
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic rr, logic is, logic e_rq, logic e_we,
                              logic [AW-1:0] e_ra, logic e_rv, logic [DW-1:0] e_rd,
                              logic e_busy);
    vec_t t;
    t.v = v; t.we = we; t.a = a; t.wd = wd; t.rr = rr; t.is = is;
    t.e_rq = e_rq; t.e_we = e_we; t.e_ra = e_ra; t.e_rv = e_rv;
    t.e_rd = e_rd; t.e_busy = e_busy;
    return t;
  endfunction

  // Entered at a falling edge: drive, compare, then advance one full cycle
  task automatic apply(input vec_t t, input string name);
    req_valid  = t.v;
    req_we     = t.we;
    req_addr   = t.a;
    req_wdata  = t.wd;
    rsp_ready  = t.rr;
    init_start = t.is;
    #1;
    n_vec++;
    if (req_ready !== t.e_rq || ram_we !== t.e_we || ram_addr !== t.e_ra ||
        rsp_valid !== t.e_rv || rsp_rdata !== t.e_rd || init_busy !== t.e_busy) begin
      n_err++;
      $display("FAIL %s @%0t: got rq=%b we=%b ra=%h rv=%b rd=%h busy=%b, want rq=%b we=%b ra=%h rv=%b rd=%h busy=%b",
               name, $time, req_ready, ram_we, ram_addr, rsp_valid, rsp_rdata, init_busy,
               t.e_rq, t.e_we, t.e_ra, t.e_rv, t.e_rd, t.e_busy);
    end
    @(negedge clk);
  endtask

  // From reset release: check 'upto' fill writes; a full fill also checks completion
  task automatic run_fill(input int upto);
    apply(mk(0, 0, 4'hF, 8'h00, 1, 0, 0, 0, 4'hF, 0, last_rd, 1), "fill_rel");
    for (int k = 0; k < upto; k++)
      apply(mk(0, 0, 4'hF, 8'h00, 1, 0, 0, 1, AW'(k), 0, last_rd, 1), "fill_wr");
    if (upto == 16)
      apply(mk(0, 0, 4'hF, 8'h00, 1, 0, 1, 0, 4'hF, 0, last_rd, 0), "fill_done");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    apply(mk(1, 0, a, 8'h00, 1, 0, 1, 0, a, 0, last_rd, 0), "rd_fire");
    apply(mk(0, 0, a, 8'h00, 1, 0, 0, 0, a, 0, last_rd, 0), "rd_wait");
    apply(mk(0, 0, a, 8'h00, 1, 0, 0, 0, a, 1, exp, 0), "rd_rsp");
    last_rd = exp;
    apply(mk(0, 0, a, 8'h00, 1, 0, 1, 0, a, 0, last_rd, 0), "rd_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Write 4 then read it, then backpressured read of 4, then read 9
    tbl[0]  = mk(1, 1, 4'h4, 8'h3C, 1, 0, 1, 1, 4'h4, 0, 8'hA5, 0);
    tbl[1]  = mk(1, 0, 4'h4, 8'h00, 1, 0, 1, 0, 4'h4, 0, 8'hA5, 0);
    tbl[2]  = mk(0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 4'h4, 0, 8'hA5, 0);
    tbl[3]  = mk(0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 4'h4, 1, 8'h3C, 0);
    tbl[4]  = mk(0, 0, 4'h0, 8'h00, 1, 0, 1, 0, 4'h0, 0, 8'h3C, 0);
    tbl[5]  = mk(1, 0, 4'h4, 8'h00, 0, 0, 1, 0, 4'h4, 0, 8'h3C, 0);
    tbl[6]  = mk(1, 1, 4'h9, 8'hFF, 0, 1, 0, 0, 4'h4, 0, 8'h3C, 0);
    for (int i = 7; i <= 11; i++)
      tbl[i] = mk(1, 1, 4'h9, 8'hFF, 0, 0, 0, 0, 4'h4, 1, 8'h3C, 0);
    tbl[12] = mk(0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 4'h4, 1, 8'h3C, 0);
    tbl[13] = mk(0, 0, 4'h0, 8'h00, 1, 0, 1, 0, 4'h0, 0, 8'h3C, 0);
    tbl[14] = mk(1, 0, 4'h9, 8'h00, 1, 0, 1, 0, 4'h9, 0, 8'h3C, 0);
    tbl[15] = mk(0, 0, 4'h9, 8'h00, 1, 0, 0, 0, 4'h9, 0, 8'h3C, 0);
    tbl[16] = mk(0, 0, 4'h9, 8'h00, 1, 0, 0, 0, 4'h9, 1, 8'hA5, 0);
    tbl[17] = mk(0, 0, 4'h0, 8'h00, 1, 0, 1, 0, 4'h0, 0, 8'hA5, 0);

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    rsp_ready = 0; init_start = 0;
    last_rd = '0;

    // Reset state
    @(negedge clk);
    apply(mk(0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 4'h0, 0, 8'h00, 1), "reset");

    // Fill after reset release, then read address 7
    rst_n = 1'b1;
    run_fill(16);
    rd(4'h7, IV);

    // Table: write/read, backpressure, plain read
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl%0d", i));
    last_rd = 8'hA5;

    // Burst writes without stall, then full readback
    for (int i = 0; i < 16; i++)
      apply(mk(1, 1, AW'(i), DW'(i) ^ 8'hFF, 1, 0, 1, 1, AW'(i), 0, last_rd, 0), "burst_wr");
    for (int i = 0; i < 16; i++) rd(AW'(i), DW'(i) ^ 8'hFF);

    // Fill request beats a concurrent write; init_start mid-fill is ignored
    apply(mk(1, 1, 4'h2, 8'h11, 1, 1, 0, 0, 4'h2, 0, last_rd, 0), "arb_start");
    for (int k = 0; k < 16; k++)
      apply(mk(1, 1, 4'h2, 8'h11, 1, (k == 5), 0, 1, AW'(k), 0, last_rd, 1), "arb_fill");
    apply(mk(1, 1, 4'h2, 8'h11, 1, 0, 1, 1, 4'h2, 0, last_rd, 0), "arb_wr");
    rd(4'h2, 8'h11);
    rd(4'h4, IV);

    // Reset while a response is held
    apply(mk(1, 0, 4'h3, 8'h00, 0, 0, 1, 0, 4'h3, 0, last_rd, 0), "rm_fire");
    apply(mk(0, 0, 4'h3, 8'h00, 0, 0, 0, 0, 4'h3, 0, last_rd, 0), "rm_wait");
    apply(mk(0, 0, 4'h3, 8'h00, 0, 0, 0, 0, 4'h3, 1, IV, 0), "rm_rsp");
    rst_n = 1'b0;
    last_rd = '0;
    apply(mk(0, 0, 4'h3, 8'h00, 0, 0, 0, 0, 4'h3, 0, 8'h00, 1), "rm_rst_rsp");

    // Reset again with fill counter at 9, then full restart from 0
    rst_n = 1'b1;
    run_fill(9);
    rst_n = 1'b0;
    apply(mk(0, 0, 4'hF, 8'h00, 0, 0, 0, 0, 4'hF, 0, 8'h00, 1), "rm_rst_fill");
    rst_n = 1'b1;
    run_fill(16);
    rd(4'h9, IV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram_access_ctrl
